memory_stage: RTL and testbench
===============================

# memory_stage

Memory stage of the five-stage RV32I pipeline: consumes the execute stage's ALU result, store data, destination register and control bundle. It performs byte/half/word loads and stores against an internal synchronous data memory. It presents the results through a registered MEM/WB boundary to the write-back stage, and exposes the EX/MEM forwarding value back to execute.

## Interface
Parameters:
- DEPTH_LOG2, 10, data memory holds 2^DEPTH_LOG2 32-bit words

Ports:
- clk  in  1  pipeline clock, all state on rising edge
- rst  in  1  synchronous, active-low reset (asserted when 0, sampled on clk rising edge)
- control_in  in  control_type  bundle from execute; uses MemRead, MemWrite, RegWrite, MemtoReg
- mem_size  in  3  RV32 funct3 of the load/store: 000 B, 001 H, 010 W, 100 BU, 101 HU
- alu_data  in  32  effective address for loads/stores, or ALU result for other ops
- memory_data  in  32  store data (rs2 value)
- rd_in  in  5  destination register
- stall  in  1  hold MEM/WB register and suppress memory write this cycle
- forward_ex_mem  out  32  combinational copy of alu_data, routed to execute's operand muxes
- control_out  out  control_type  registered control_in
- alu_data_out  out  32  registered alu_data
- mem_data_out  out  32  load result, extended per mem_size
- rd_out  out  5  registered rd_in
- misaligned  out  1  registered fault flag for the op now at the outputs

## Operation
- Word index is alu_data[DEPTH_LOG2+1:2]. Upper address bits are ignored, so the index wraps modulo depth. The byte offset is alu_data[1:0].
- Alignment rule:
  - W requires offset 00.
  - H/HU requires offset[0]=0.
  - B/BU accept any offset.
  - A violation with MemRead or MemWrite set raises misaligned.
- Store (MemWrite=1, aligned, stall=0, rst=1):
  - Write with byte enables.
  - SB writes byte lane offset with memory_data[7:0].
  - SH writes lanes offset and offset+1 with memory_data[15:0].
  - SW writes all lanes.
  - Unwritten lanes are unchanged.
  - A misaligned store writes nothing.
- Load (MemRead=1):
  - Memory is read synchronously.
  - The selected lane(s) are extracted using the registered offset and mem_size.
  - B/H sign-extend; BU/HU zero-extend; W passes through.
  - A misaligned load gives mem_data_out=0.
- MemRead and MemWrite both set: the op is treated as a store only, and mem_data_out=0.
- Neither set: mem_data_out=0 and misaligned=0.
- Undefined mem_size codes (011, 110, 111): treated as W.
- Memory contents are not affected by rst.
- forward_ex_mem = alu_data, purely combinational with no added latency.

## Timing
- Reset (rst=0 at an edge) clears:
  - control_out to all zero fields
  - alu_data_out, mem_data_out and rd_out to 0
  - misaligned to 0
- During reset no memory write occurs, and reset has priority over stall.
- An op presented in cycle N appears on all registered outputs in cycle N+1. Load latency is 1 cycle.
- A store presented in cycle N commits at the edge ending cycle N.
- A load to the same word in cycle N+1 returns the new data; no bypass logic is needed.
- Stall=1 in cycle N:
  - Outputs keep their cycle-N values in N+1.
  - The memory write for the op is suppressed.
  - The RAM read port is not advanced, so mem_data_out stays stable.
  - Upstream re-presents the op when stall drops.
- misaligned is valid for exactly the cycle(s) its op occupies the outputs. It is not sticky.

## Test plan
- Reset: drive rst=0 for 2 cycles with MemWrite=1 and addr 0x10 -> all outputs 0; word 4 unchanged after release.
- SW 0xDEADBEEF to 0x20, then LW 0x20 next cycle -> mem_data_out=0xDEADBEEF one cycle after the load.
- Sub-word loads, with word 0x20 = 0x8001FF7F:
  - LB 0x20 -> 0x0000007F
  - LB 0x21 -> 0xFFFFFFFF
  - LBU 0x21 -> 0x000000FF
  - LH 0x22 -> 0xFFFF8001
  - LHU 0x22 -> 0x00008001
- Sub-word stores: SB 0xAA to 0x23, then SH 0x1234 to 0x20, then LW 0x20 -> 0xAA011234.
- Misaligned: SW to 0x22 -> misaligned=1 next cycle and word 8 unchanged. LH at 0x21 -> misaligned=1 and mem_data_out=0.
- Stall and passthrough:
  - Stall=1 during SW 0x55 to 0x30 -> outputs hold and memory unchanged.
  - Releasing stall commits the store.
  - A non-memory op with alu_data=0x1234, rd=7 -> alu_data_out=0x1234 and rd_out=7 one cycle later.
  - forward_ex_mem tracks alu_data in the same cycle.

Source files
------------

// File: rtl/memory_stage.sv
// Memory stage of the RV32I pipeline: byte-enabled synchronous data RAM,
// sub-word load extraction and the registered MEM/WB boundary.
package memory_stage_pkg;
    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic reg_write;
        logic mem_to_reg;
    } control_type;
endpackage

module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  control_type control_in,
    input  logic [2:0]  mem_size,
    input  logic [31:0] alu_data,
    input  logic [31:0] memory_data,
    input  logic [4:0]  rd_in,
    input  logic        stall,
    output logic [31:0] forward_ex_mem,
    output control_type control_out,
    output logic [31:0] alu_data_out,
    output logic [31:0] mem_data_out,
    output logic [4:0]  rd_out,
    output logic        misaligned
);

    logic [31:0] mem [2**DEPTH_LOG2];

    logic [DEPTH_LOG2-1:0] index;
    logic [1:0]            offset;
    logic                  misalign_d, misalign_q;
    logic                  load_d, load_q;
    logic                  wr_en;
    logic [3:0]            byte_en;
    logic [31:0]           wr_data;
    control_type           ctrl_d, ctrl_q;
    logic [31:0]           alu_d, alu_q;
    logic [4:0]            rd_d, rd_q;
    logic [2:0]            size_d, size_q;
    logic [31:0]           rdata_d, rdata_q;
    logic [31:0]           lane;
    logic [31:0]           load_result;

    assign index          = alu_data[DEPTH_LOG2+1:2];
    assign offset         = alu_data[1:0];
    assign forward_ex_mem = alu_data;

    // mem_size[1:0]: 00 byte, 01 half, anything else is a word access.
    always_comb begin
        misalign_d = 1'b0;
        byte_en    = 4'b1111;
        wr_data    = memory_data;
        case (mem_size[1:0])
            2'b00: begin
                byte_en = 4'b0001 << offset;
                wr_data = {4{memory_data[7:0]}};
            end
            2'b01: begin
                misalign_d = offset[0];
                byte_en    = offset[1] ? 4'b1100 : 4'b0011;
                wr_data    = {2{memory_data[15:0]}};
            end
            default: misalign_d = (offset != 2'b00);
        endcase
        if (!(control_in.mem_read || control_in.mem_write))
            misalign_d = 1'b0;
    end

    assign wr_en  = control_in.mem_write && !misalign_d && !stall && rst;
    assign load_d = control_in.mem_read && !control_in.mem_write && !misalign_d;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) mem[index][i*8 +: 8] <= wr_data[i*8 +: 8];
            end
        end
    end

    always_comb begin
        ctrl_d  = ctrl_q;
        alu_d   = alu_q;
        rd_d    = rd_q;
        size_d  = size_q;
        rdata_d = rdata_q;
        if (!stall) begin
            ctrl_d  = control_in;
            alu_d   = alu_data;
            rd_d    = rd_in;
            size_d  = mem_size;
            rdata_d = mem[index];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ctrl_q     <= '0;
            alu_q      <= '0;
            rd_q       <= '0;
            size_q     <= '0;
            misalign_q <= 1'b0;
            load_q     <= 1'b0;
        end else if (!stall) begin
            ctrl_q     <= ctrl_d;
            alu_q      <= alu_d;
            rd_q       <= rd_d;
            size_q     <= size_d;
            misalign_q <= misalign_d;
            load_q     <= load_d;
        end
        rdata_q <= rdata_d;
    end

    // Lane extraction uses the offset of the op now at the outputs.
    always_comb begin
        lane        = rdata_q >> {alu_q[1:0], 3'b000};
        load_result = rdata_q;
        case (size_q[1:0])
            2'b00: load_result = {{24{lane[7] & ~size_q[2]}}, lane[7:0]};
            2'b01: load_result = {{16{lane[15] & ~size_q[2]}}, lane[15:0]};
            default: load_result = rdata_q;
        endcase
        if (!load_q) load_result = '0;
    end

    assign control_out  = ctrl_q;
    assign alu_data_out = alu_q;
    assign rd_out       = rd_q;
    assign misaligned   = misalign_q;
    assign mem_data_out = load_result;

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: reset, loads/stores of every width,
// misalignment, stall hold and ALU passthrough.
module tb_memory_stage;
    import memory_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    control_type control_in;
    logic [2:0]  mem_size;
    logic [31:0] alu_data, memory_data;
    logic [4:0]  rd_in;
    logic        stall;
    logic [31:0] forward_ex_mem, alu_data_out, mem_data_out;
    control_type control_out;
    logic [4:0]  rd_out;
    logic        misaligned;

    int checks   = 0;
    int failures = 0;

    localparam logic [2:0] SZ_B = 3'b000, SZ_H = 3'b001, SZ_W = 3'b010,
                           SZ_BU = 3'b100, SZ_HU = 3'b101;

    memory_stage #(.DEPTH_LOG2(10)) dut (
        .clk(clk), .rst(rst), .control_in(control_in), .mem_size(mem_size),
        .alu_data(alu_data), .memory_data(memory_data), .rd_in(rd_in),
        .stall(stall), .forward_ex_mem(forward_ex_mem),
        .control_out(control_out), .alu_data_out(alu_data_out),
        .mem_data_out(mem_data_out), .rd_out(rd_out), .misaligned(misaligned)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one op, check the combinational forward path, then clock it.
    task automatic op(input logic rd_en, input logic wr_en, input logic [2:0] sz,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [4:0] rd, input logic stl);
        control_in  = '{mem_read: rd_en, mem_write: wr_en, reg_write: 1'b1, mem_to_reg: rd_en};
        mem_size    = sz;
        alu_data    = addr;
        memory_data = wdata;
        rd_in       = rd;
        stall       = stl;
        #1;
        chk("forward", forward_ex_mem, addr);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        op(0, 1, SZ_W, 32'h10, 32'hCAFEBABE, 5'd9, 0);
        chk("rst_alu", alu_data_out, 32'h0);
        chk("rst_rd", {27'b0, rd_out}, 32'h0);
        chk("rst_mdata", mem_data_out, 32'h0);
        chk("rst_mis", {31'b0, misaligned}, 32'h0);
        chk("rst_ctrl", {28'b0, control_out}, 32'h0);

        rst = 1'b1;
        op(0, 1, SZ_W, 32'h10, 32'h11111111, 5'd0, 0);
        rst = 1'b0;
        op(0, 1, SZ_W, 32'h10, 32'hCAFEBABE, 5'd0, 0);
        op(0, 1, SZ_W, 32'h10, 32'hCAFEBABE, 5'd0, 1);
        chk("rst2_alu", alu_data_out, 32'h0);
        chk("rst2_ctrl", {28'b0, control_out}, 32'h0);
        rst = 1'b1;
        op(1, 0, SZ_W, 32'h10, 32'h0, 5'd1, 0);
        chk("rst_no_write", mem_data_out, 32'h11111111);

        op(0, 1, SZ_W, 32'h20, 32'hDEADBEEF, 5'd0, 0);
        op(1, 0, SZ_W, 32'h20, 32'h0, 5'd2, 0);
        chk("lw_after_sw", mem_data_out, 32'hDEADBEEF);
        chk("lw_rd", {27'b0, rd_out}, 32'd2);

        op(0, 1, SZ_W, 32'h20, 32'h8001FF7F, 5'd0, 0);
        op(1, 0, SZ_B, 32'h20, 32'h0, 5'd3, 0);
        chk("lb_20", mem_data_out, 32'h0000007F);
        op(1, 0, SZ_B, 32'h21, 32'h0, 5'd3, 0);
        chk("lb_21", mem_data_out, 32'hFFFFFFFF);
        op(1, 0, SZ_BU, 32'h21, 32'h0, 5'd3, 0);
        chk("lbu_21", mem_data_out, 32'h000000FF);
        op(1, 0, SZ_H, 32'h22, 32'h0, 5'd3, 0);
        chk("lh_22", mem_data_out, 32'hFFFF8001);
        op(1, 0, SZ_HU, 32'h22, 32'h0, 5'd3, 0);
        chk("lhu_22", mem_data_out, 32'h00008001);

        op(0, 1, SZ_B, 32'h23, 32'h000000AA, 5'd0, 0);
        op(0, 1, SZ_H, 32'h20, 32'hFFFF1234, 5'd0, 0);
        op(1, 0, SZ_W, 32'h20, 32'h0, 5'd4, 0);
        chk("sb_sh_merge", mem_data_out, 32'hAA011234);

        op(0, 1, SZ_W, 32'h22, 32'h77777777, 5'd0, 0);
        chk("sw_mis_flag", {31'b0, misaligned}, 32'h1);
        op(1, 0, SZ_W, 32'h20, 32'h0, 5'd4, 0);
        chk("sw_mis_nowrite", mem_data_out, 32'hAA011234);
        chk("mis_not_sticky", {31'b0, misaligned}, 32'h0);
        op(1, 0, SZ_H, 32'h21, 32'h0, 5'd4, 0);
        chk("lh_mis_flag", {31'b0, misaligned}, 32'h1);
        chk("lh_mis_data", mem_data_out, 32'h0);

        op(0, 1, SZ_W, 32'h30, 32'h0, 5'd0, 0);
        op(1, 0, SZ_W, 32'h20, 32'h0, 5'd5, 0);
        op(0, 1, SZ_W, 32'h30, 32'h55, 5'd0, 1);
        chk("stall_alu_hold", alu_data_out, 32'h20);
        chk("stall_rd_hold", {27'b0, rd_out}, 32'd5);
        chk("stall_mdata_hold", mem_data_out, 32'hAA011234);
        op(1, 0, SZ_W, 32'h30, 32'h0, 5'd5, 0);
        chk("stall_no_write", mem_data_out, 32'h0);
        op(0, 1, SZ_W, 32'h30, 32'h55, 5'd0, 0);
        op(1, 0, SZ_W, 32'h30, 32'h0, 5'd5, 0);
        chk("unstall_commit", mem_data_out, 32'h55);

        op(1, 1, SZ_W, 32'h40, 32'h0000ABCD, 5'd6, 0);
        chk("rw_both_mdata", mem_data_out, 32'h0);
        op(1, 0, 3'b011, 32'h40, 32'h0, 5'd6, 0);
        chk("rw_both_stored_undef_sz", mem_data_out, 32'h0000ABCD);
        op(1, 0, 3'b011, 32'h42, 32'h0, 5'd6, 0);
        chk("undef_sz_mis", {31'b0, misaligned}, 32'h1);

        op(0, 0, SZ_W, 32'h1234, 32'h0, 5'd7, 0);
        chk("pass_alu", alu_data_out, 32'h1234);
        chk("pass_rd", {27'b0, rd_out}, 32'd7);
        chk("pass_ctrl", {28'b0, control_out}, 32'h2);
        chk("pass_mdata", mem_data_out, 32'h0);
        chk("pass_mis", {31'b0, misaligned}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
